// File: rtl/gadget_field.sv
// gadget_field: per-cell power-up states with timed reveal, guard window and expiry,
// plus lowest-index-wins pickup arbitration and per-player capacity/length tracking.
module gadget_field #(
    parameter  int GRID_W        = 16,
    parameter  int GRID_H        = 16,
    parameter  int N_PLAYER      = 2,
    parameter  int INIT_CAP      = 1,
    parameter  int MAX_CAP       = 4,
    parameter  int INIT_LEN      = 0,
    parameter  int MAX_LEN       = 3,
    parameter  int REVEAL_CYCLES = 18,
    parameter  int GUARD_CYCLES  = 4,
    parameter  int EXPIRE_CYCLES = 0,
    localparam int N             = GRID_W * GRID_H,
    localparam int CW            = $clog2(N),
    localparam int CAPW          = $clog2(MAX_CAP + 1),
    localparam int LENW          = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_setup,
    input  logic                     i_wr_en,
    input  logic [CW-1:0]            i_wr_idx,
    input  logic [2:0]               i_wr_kind,
    input  logic [N_PLAYER*CW-1:0]   i_player_cor,
    input  logic [N_PLAYER-1:0]      i_player_alive,
    input  logic [N-1:0]             i_explode,
    output logic [N_PLAYER*CAPW-1:0] o_cap,
    output logic [N_PLAYER*LENW-1:0] o_len,
    output logic [3*N-1:0]           o_grid,
    output logic [N_PLAYER-1:0]      o_pickup_valid,
    output logic [2*N_PLAYER-1:0]    o_pickup_kind
);
    localparam int RG   = (REVEAL_CYCLES > GUARD_CYCLES) ? REVEAL_CYCLES : GUARD_CYCLES;
    localparam int CNTW = $clog2(((RG > EXPIRE_CYCLES) ? RG : EXPIRE_CYCLES) + 1);

    typedef enum logic [2:0] {
        EMPTY, LOTION, ADD_BOMB, HIDE_LOTION, HIDE_ADD_BOMB, REVEAL_LOTION, REVEAL_ADD_BOMB
    } cell_e;

    cell_e           grid_q [N];
    cell_e           grid_d [N];
    logic [CNTW-1:0] cnt_q [N];
    logic [CNTW-1:0] cnt_d [N];
    logic [CAPW-1:0] cap_q [N_PLAYER];
    logic [LENW-1:0] len_q [N_PLAYER];
    logic [1:0]      pk_q [N_PLAYER];
    logic [N_PLAYER-1:0] pv_q;
    logic [CW-1:0]   cor [N_PLAYER];
    cell_e           at [N_PLAYER];
    logic [1:0]      win_kind [N_PLAYER];
    logic [N_PLAYER-1:0] on_grid, win;
    logic [N-1:0]    taken;

    for (genvar g = 0; g < N_PLAYER; g++) begin : g_pl
        assign cor[g]     = i_player_cor[g*CW +: CW];
        assign on_grid[g] = {1'b0, cor[g]} < (CW+1)'(N);
        assign at[g]      = on_grid[g] ? grid_q[cor[g]] : EMPTY;
        assign o_cap[g*CAPW +: CAPW]   = cap_q[g];
        assign o_len[g*LENW +: LENW]   = len_q[g];
        assign o_pickup_kind[2*g +: 2] = pk_q[g];
    end
    for (genvar k = 0; k < N; k++) begin : g_cell
        assign o_grid[3*k +: 3] = grid_q[k];
    end
    assign o_pickup_valid = pv_q;

    // Ascending scan marks a cell taken so higher-index players on it lose.
    always_comb begin
        win   = '0;
        taken = '0;
        for (int p = 0; p < N_PLAYER; p++) begin
            win_kind[p] = 2'd0;
            if (!i_setup && i_player_alive[p] && on_grid[p] && (at[p] == LOTION || at[p] == ADD_BOMB) && !taken[cor[p]]) begin
                win[p]          = 1'b1;
                taken[cor[p]]   = 1'b1;
                win_kind[p]     = at[p][1:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            grid_d[k] = grid_q[k];
            cnt_d[k]  = cnt_q[k];
            if (i_setup) begin
                if (i_wr_en && i_wr_idx == CW'(k)) begin
                    grid_d[k] = cell_e'(i_wr_kind > 3'd4 ? 3'd0 : i_wr_kind);
                    cnt_d[k]  = '0;
                end
            end else if (taken[k]) begin
                grid_d[k] = EMPTY;
                cnt_d[k]  = '0;
            end else begin
                case (grid_q[k])
                    HIDE_LOTION, HIDE_ADD_BOMB: if (i_explode[k]) begin
                        grid_d[k] = cell_e'(grid_q[k] + 3'd2);
                        cnt_d[k]  = '0;
                    end
                    REVEAL_LOTION, REVEAL_ADD_BOMB: begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                        if (cnt_q[k] == CNTW'(REVEAL_CYCLES - 1)) begin
                            grid_d[k] = cell_e'(grid_q[k] - 3'd4);
                            cnt_d[k]  = '0;
                        end
                    end
                    LOTION, ADD_BOMB: begin
                        cnt_d[k] = (&cnt_q[k]) ? cnt_q[k] : cnt_q[k] + 1'b1;
                        if ((i_explode[k] && cnt_q[k] >= CNTW'(GUARD_CYCLES)) ||
                            (EXPIRE_CYCLES != 0 && cnt_q[k] == CNTW'(EXPIRE_CYCLES - 1))) begin
                            grid_d[k] = EMPTY;
                            cnt_d[k]  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                grid_q[k] <= EMPTY;
                cnt_q[k]  <= '0;
            end
            for (int p = 0; p < N_PLAYER; p++) begin
                cap_q[p] <= CAPW'(INIT_CAP);
                len_q[p] <= LENW'(INIT_LEN);
                pk_q[p]  <= '0;
            end
            pv_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                grid_q[k] <= grid_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            for (int p = 0; p < N_PLAYER; p++) begin
                cap_q[p] <= i_setup ? CAPW'(INIT_CAP) :
                            (win_kind[p] == 2'd2 && cap_q[p] < CAPW'(MAX_CAP)) ? cap_q[p] + 1'b1 : cap_q[p];
                len_q[p] <= i_setup ? LENW'(INIT_LEN) :
                            (win_kind[p] == 2'd1 && len_q[p] < LENW'(MAX_LEN)) ? len_q[p] + 1'b1 : len_q[p];
                pk_q[p]  <= win_kind[p];
            end
            pv_q <= win;
        end
    end
endmodule

// File: tb/tb_gadget_field.sv
// tb_gadget_field: two builds (expiry 20 and no expiry) on a 17x17 grid, driven identically
// and checked against a cell-rule reference model with a pickup scoreboard.
module tb_gadget_field;
    localparam int GW = 17, GH = 17, N = GW * GH, CW = $clog2(N), NP = 2;
    localparam int R = 18, G = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, setup, wr_en;
    logic [CW-1:0] wr_idx;
    logic [2:0] wr_kind;
    logic [NP*CW-1:0] cor;
    logic [NP-1:0] alive;
    logic [N-1:0] explode;
    logic [3*N-1:0] grid_o [2];
    logic [NP*3-1:0] cap_o [2];
    logic [NP*2-1:0] len_o [2];
    logic [NP-1:0] pv_o [2];
    logic [2*NP-1:0] pk_o [2];

    gadget_field #(.GRID_W(GW), .GRID_H(GH), .EXPIRE_CYCLES(20)) ua (
        .clk(clk), .rst_n(rst_n), .i_setup(setup), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
        .i_wr_kind(wr_kind), .i_player_cor(cor), .i_player_alive(alive), .i_explode(explode),
        .o_cap(cap_o[0]), .o_len(len_o[0]), .o_grid(grid_o[0]),
        .o_pickup_valid(pv_o[0]), .o_pickup_kind(pk_o[0]));
    gadget_field #(.GRID_W(GW), .GRID_H(GH)) ub (
        .clk(clk), .rst_n(rst_n), .i_setup(setup), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
        .i_wr_kind(wr_kind), .i_player_cor(cor), .i_player_alive(alive), .i_explode(explode),
        .o_cap(cap_o[1]), .o_len(len_o[1]), .o_grid(grid_o[1]),
        .o_pickup_valid(pv_o[1]), .o_pickup_kind(pk_o[1]));

    int st [2][N];
    int age [2][N];
    int cap [2][NP];
    int len [2][NP];
    int sbq [4][$];
    int checks = 0, errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin st[i][k] = 0; age[i][k] = 0; end
            for (int p = 0; p < NP; p++) begin cap[i][p] = 1; len[i][p] = 0; sbq[2*i+p].delete(); end
        end
    endtask

    task automatic model_step(input int i, input int e);
        bit taken [N];
        int c, kd;
        if (setup) begin
            if (wr_en && int'(wr_idx) < N) begin
                st[i][wr_idx]  = (wr_kind > 4) ? 0 : int'(wr_kind);
                age[i][wr_idx] = 0;
            end
            for (int p = 0; p < NP; p++) begin cap[i][p] = 1; len[i][p] = 0; end
        end else begin
            for (int k = 0; k < N; k++) taken[k] = 0;
            for (int p = 0; p < NP; p++) begin
                c = int'(cor[p*CW +: CW]);
                if (alive[p] && c < N) begin
                    if (!taken[c] && (st[i][c] == 1 || st[i][c] == 2)) begin
                        taken[c] = 1;
                        kd = st[i][c];
                        sbq[2*i+p].push_back(kd);
                        if (kd == 1) len[i][p] = (len[i][p] < 3) ? len[i][p] + 1 : 3;
                        else         cap[i][p] = (cap[i][p] < 4) ? cap[i][p] + 1 : 4;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (taken[k]) begin
                    st[i][k] = 0; age[i][k] = 0;
                end else if (st[i][k] == 3 || st[i][k] == 4) begin
                    if (explode[k]) begin st[i][k] += 2; age[i][k] = 0; end
                end else if (st[i][k] == 5 || st[i][k] == 6) begin
                    if (age[i][k] == R - 1) begin st[i][k] -= 4; age[i][k] = 0; end
                    else age[i][k]++;
                end else if (st[i][k] == 1 || st[i][k] == 2) begin
                    if ((explode[k] && age[i][k] >= G) || (e != 0 && age[i][k] == e - 1)) st[i][k] = 0;
                    else age[i][k]++;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0, 20);
            model_step(1, 0);
        end
    end

    always @(negedge clk) begin
        int ek, bad;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < NP; p++) begin
                    checks++;
                    if (pv_o[i][p] === 1'b1) begin
                        ek = (sbq[2*i+p].size() > 0) ? sbq[2*i+p].pop_front() : -1;
                        if (ek < 0 || pk_o[i][2*p +: 2] !== 2'(ek)) begin
                            errors++;
                            $display("FAIL pickup inst%0d p%0d: got valid=1 kind=%0d, expected kind=%0d (-1: no pickup)", i, p, pk_o[i][2*p +: 2], ek);
                        end
                    end else if (sbq[2*i+p].size() > 0 || pv_o[i][p] !== 1'b0 || pk_o[i][2*p +: 2] !== 2'd0) begin
                        ek = (sbq[2*i+p].size() > 0) ? sbq[2*i+p].pop_front() : 0;
                        errors++;
                        $display("FAIL pickup inst%0d p%0d: got valid=%b kind=%0d, expected valid=%0d kind=%0d", i, p, pv_o[i][p], pk_o[i][2*p +: 2], ek != 0, ek);
                    end
                    checks++;
                    if (cap_o[i][3*p +: 3] !== 3'(cap[i][p]) || len_o[i][2*p +: 2] !== 2'(len[i][p])) begin
                        errors++;
                        $display("FAIL caplen inst%0d p%0d: got cap=%0d len=%0d, expected cap=%0d len=%0d", i, p, cap_o[i][3*p +: 3], len_o[i][2*p +: 2], cap[i][p], len[i][p]);
                    end
                end
                bad = -1;
                for (int k = N - 1; k >= 0; k--) if (grid_o[i][3*k +: 3] !== 3'(st[i][k])) bad = k;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL grid inst%0d cell %0d: got %0d, expected %0d", i, bad, grid_o[i][3*bad +: 3], st[i][bad]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int idx, input int kind);
        setup = 1'b1; wr_en = 1'b1; wr_idx = CW'(idx); wr_kind = 3'(kind);
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic place(input int c0, input int c1, input logic [1:0] al);
        cor[0 +: CW] = CW'(c0); cor[CW +: CW] = CW'(c1); alive = al;
    endtask

    initial begin
        int sl;
        rst_n = 1'b0; setup = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_kind = '0;
        cor = '0; alive = '0; explode = '0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        // layout: one out-of-range write and two illegal kinds that must land as EMPTY
        wr(4, 4); wr(19, 3); wr(300, 2); wr(7, 5); wr(8, 7);
        wr(10, 1); wr(11, 1); wr(12, 1); wr(13, 1);
        wr(20, 3); wr(21, 4);
        setup = 1'b0;
        tick(1);
        for (int c = 10; c < 14; c++) begin place(c, c, 2'b11); tick(1); end
        place(288, 288, 2'b00);
        explode[4] = 1'b1; tick(1); explode[4] = 1'b0;
        tick(24);
        place(4, 288, 2'b01); tick(1);
        place(288, 288, 2'b00); tick(2);
        explode[20] = 1'b1; explode[21] = 1'b1; tick(1); explode[21] = 1'b0;
        tick(45);
        explode[20] = 1'b0;
        wr(22, 3); wr(23, 4);
        setup = 1'b0;
        explode[22] = 1'b1; tick(1); explode[22] = 1'b0;
        tick(5);
        setup = 1'b1; tick(6); setup = 1'b0;
        tick(20);
        explode[23] = 1'b1; tick(1); explode[23] = 1'b0;
        tick(7);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grid_o[i][3*23 +: 3] !== 3'd0 || pv_o[i] !== 2'b00 || cap_o[i] !== {3'd1, 3'd1}) begin
                errors++;
                $display("FAIL async_reset inst%0d: got cell23=%0d valid=%b cap=%h, expected 0 0 9", i, grid_o[i][3*23 +: 3], pv_o[i], cap_o[i]);
            end
        end
        tick(2);
        rst_n = 1'b1;
        explode[23] = 1'b1; tick(3); explode[23] = 1'b0;
        sl = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            explode = '0;
            repeat ($urandom_range(0, 3)) explode[$urandom_range(0, 39)] = 1'b1;
            if (!setup) begin
                place($urandom_range(0, 9) == 0 ? $urandom_range(289, 511) : $urandom_range(0, 40),
                      $urandom_range(0, 40), 2'($urandom));
                if ($urandom_range(0, 59) == 0) begin setup = 1'b1; sl = $urandom_range(2, 8); end
            end else begin
                wr_en   = $urandom_range(0, 3) != 0;
                wr_idx  = CW'($urandom_range(0, 9) == 0 ? $urandom_range(289, 511) : $urandom_range(0, 39));
                wr_kind = 3'($urandom);
                sl--;
                if (sl <= 0) begin setup = 1'b0; wr_en = 1'b0; end
            end
        end
        setup = 1'b0; wr_en = 1'b0; explode = '0; alive = '0;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
